// File: rtl/pad_motion_ctrl_if.sv
// rtl/pad_motion_ctrl_if.sv - control/status bundle between game logic and the pad motion block
interface pad_motion_ctrl_if #(
  parameter int Y_W = 10
);
  logic           timing_tick;
  logic           up_in;
  logic           down_in;
  logic           mode;
  logic [Y_W-1:0] ball_y;
  logic [1:0]     state;
  logic [Y_W-1:0] y_pad;
  logic [2:0]     velocity;
  logic           moving;
  logic           hit_top;
  logic           hit_bottom;

  modport slave (
    input  timing_tick, up_in, down_in, mode, ball_y, state,
    output y_pad, velocity, moving, hit_top, hit_bottom
  );

  modport master (
    output timing_tick, up_in, down_in, mode, ball_y, state,
    input  y_pad, velocity, moving, hit_top, hit_bottom
  );
endinterface

// File: rtl/pad_motion_ctrl.sv
// rtl/pad_motion_ctrl.sv - tick-paced pad mover with acceleration, edge clamping and auto-tracking
module pad_motion_ctrl #(
  parameter int         Y_W         = 10,
  parameter int         PAD_HEIGHT  = 145,
  parameter int         Y_RESET     = 312,
  parameter int         Y_MIN       = 1,
  parameter int         Y_MAX       = 766,
  parameter int         V_MIN       = 1,
  parameter int         V_MAX       = 4,
  parameter int         ACCEL_TICKS = 4,
  parameter int         DEADBAND    = 4,
  parameter logic [1:0] PLAY_CODE   = 2'b01
) (
  input logic              clk,
  input logic              rst,
  pad_motion_ctrl_if.slave bus
);

  localparam int CW = $clog2(ACCEL_TICKS + 1);

  localparam logic [Y_W:0]   L_HALF   = (Y_W+1)'(PAD_HEIGHT / 2);
  localparam logic [Y_W:0]   L_DB     = (Y_W+1)'(DEADBAND);
  localparam logic [Y_W:0]   L_PH_M1  = (Y_W+1)'(PAD_HEIGHT - 1);
  localparam logic [Y_W:0]   L_YMAX   = (Y_W+1)'(Y_MAX);
  localparam logic [Y_W:0]   L_YMIN   = (Y_W+1)'(Y_MIN);
  localparam logic [Y_W-1:0] L_YRST   = Y_W'(Y_RESET);
  localparam logic [Y_W-1:0] L_YBOT   = Y_W'(Y_MAX - PAD_HEIGHT + 1);
  localparam logic [Y_W-1:0] L_YTOP   = Y_W'(Y_MIN);
  localparam logic [2:0]     L_VMIN   = 3'(V_MIN);
  localparam logic [2:0]     L_VMAX   = 3'(V_MAX);
  localparam logic [CW-1:0]  L_ACC    = CW'(ACCEL_TICKS);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN} state_t;
  typedef enum logic [1:0] {REQ_NONE, REQ_UP, REQ_DOWN} req_t;

  state_t         r_state;
  logic [Y_W-1:0] r_y;
  logic [2:0]     r_vel;
  logic [CW-1:0]  r_cnt;
  logic           r_hit_top;
  logic           r_hit_bot;
  logic           r_up_meta, r_up_sync;
  logic           r_dn_meta, r_dn_sync;

  state_t         w_state_nxt;
  logic [Y_W-1:0] w_y_nxt;
  logic [2:0]     w_vel_nxt;
  logic [CW-1:0]  w_cnt_nxt;
  logic           w_hit_top_nxt;
  logic           w_hit_bot_nxt;
  req_t           w_req;
  logic           w_same_dir;
  logic [2:0]     w_step;
  logic [CW-1:0]  w_cnt_inc;
  logic [Y_W:0]   w_y_ext;
  logic [Y_W:0]   w_step_ext;
  logic [Y_W:0]   w_center;
  logic [Y_W:0]   w_ball;

  assign w_y_ext  = {1'b0, r_y};
  assign w_center = w_y_ext + L_HALF;
  assign w_ball   = {1'b0, bus.ball_y};

  // Deadband is applied on the ball side so center-DEADBAND can never underflow.
  always_comb begin
    w_req = REQ_NONE;
    if (bus.mode) begin
      if (w_ball + L_DB < w_center)
        w_req = REQ_UP;
      else if (w_ball > w_center + L_DB)
        w_req = REQ_DOWN;
    end else if (r_up_sync && !r_dn_sync) begin
      w_req = REQ_UP;
    end else if (r_dn_sync && !r_up_sync) begin
      w_req = REQ_DOWN;
    end
  end

  assign w_same_dir = (w_req == REQ_UP && r_state == S_UP) ||
                      (w_req == REQ_DOWN && r_state == S_DOWN);

  always_comb begin
    w_state_nxt   = r_state;
    w_y_nxt       = r_y;
    w_vel_nxt     = r_vel;
    w_cnt_nxt     = r_cnt;
    w_hit_top_nxt = 1'b0;
    w_hit_bot_nxt = 1'b0;
    w_step        = L_VMIN;
    w_cnt_inc     = r_cnt + CW'(1);
    w_step_ext    = '0;

    if (bus.state != PLAY_CODE) begin
      w_state_nxt = S_IDLE;
      w_y_nxt     = L_YRST;
      w_vel_nxt   = '0;
      w_cnt_nxt   = '0;
    end else if (bus.timing_tick) begin
      if (w_req == REQ_NONE) begin
        w_state_nxt = S_IDLE;
        w_vel_nxt   = '0;
        w_cnt_nxt   = '0;
      end else begin
        if (w_same_dir) begin
          w_step = r_vel;
          if (w_cnt_inc == L_ACC) begin
            w_vel_nxt = (r_vel >= L_VMAX) ? L_VMAX : r_vel + 3'd1;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end else begin
          w_step    = L_VMIN;
          w_vel_nxt = L_VMIN;
          w_cnt_nxt = CW'(1);
        end
        w_step_ext = (Y_W+1)'(w_step);

        // A clamp restarts acceleration from scratch.
        if (w_req == REQ_DOWN) begin
          w_state_nxt = S_DOWN;
          if (w_y_ext + L_PH_M1 + w_step_ext <= L_YMAX) begin
            w_y_nxt = r_y + Y_W'(w_step);
          end else begin
            w_y_nxt       = L_YBOT;
            w_hit_bot_nxt = 1'b1;
            w_vel_nxt     = L_VMIN;
            w_cnt_nxt     = '0;
          end
        end else begin
          w_state_nxt = S_UP;
          if (w_y_ext >= L_YMIN + w_step_ext) begin
            w_y_nxt = r_y - Y_W'(w_step);
          end else begin
            w_y_nxt       = L_YTOP;
            w_hit_top_nxt = 1'b1;
            w_vel_nxt     = L_VMIN;
            w_cnt_nxt     = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_y       <= L_YRST;
      r_vel     <= '0;
      r_cnt     <= '0;
      r_hit_top <= 1'b0;
      r_hit_bot <= 1'b0;
      r_up_meta <= 1'b0;
      r_up_sync <= 1'b0;
      r_dn_meta <= 1'b0;
      r_dn_sync <= 1'b0;
    end else begin
      r_up_meta <= bus.up_in;
      r_up_sync <= r_up_meta;
      r_dn_meta <= bus.down_in;
      r_dn_sync <= r_dn_meta;
      r_state   <= w_state_nxt;
      r_y       <= w_y_nxt;
      r_vel     <= w_vel_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hit_top <= w_hit_top_nxt;
      r_hit_bot <= w_hit_bot_nxt;
    end
  end

  assign bus.y_pad      = r_y;
  assign bus.velocity   = r_vel;
  assign bus.moving     = (r_state != S_IDLE);
  assign bus.hit_top    = r_hit_top;
  assign bus.hit_bottom = r_hit_bot;

endmodule

// File: tb/tb_pad_motion_ctrl.sv
// tb/tb_pad_motion_ctrl.sv - directed and random checks of pad_motion_ctrl against a behavioural model
module tb_pad_motion_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pad_motion_ctrl_if #(.Y_W(10)) bus ();

  pad_motion_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model state: position, speed, same-direction count, direction (0 idle, 1 up, 2 down)
  int m_y, m_v, m_cnt, m_dir, m_ht, m_hb;
  int m_s1u, m_s2u, m_s1d, m_s2d;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_y = 312; m_v = 0; m_cnt = 0; m_dir = 0; m_ht = 0; m_hb = 0;
    m_s1u = 0; m_s2u = 0; m_s1d = 0; m_s2d = 0;
  endtask

  task automatic model_edge();
    int req, center, step;
    if (bus.mode) begin
      center = m_y + 72;
      if (int'(bus.ball_y) < center - 4) req = 1;
      else if (int'(bus.ball_y) > center + 4) req = 2;
      else req = 0;
    end else begin
      req = (m_s2u == 1 && m_s2d == 0) ? 1 : (m_s2d == 1 && m_s2u == 0) ? 2 : 0;
    end
    m_ht = 0;
    m_hb = 0;
    if (bus.state != 2'b01) begin
      m_y = 312; m_dir = 0; m_v = 0; m_cnt = 0;
    end else if (bus.timing_tick) begin
      if (req == 0) begin
        m_dir = 0; m_v = 0; m_cnt = 0;
      end else begin
        if (req != m_dir) begin
          step = 1; m_v = 1; m_cnt = 1; m_dir = req;
        end else begin
          step = m_v;
          m_cnt = m_cnt + 1;
          if (m_cnt == 4) begin
            m_v = (m_v + 1 > 4) ? 4 : m_v + 1;
            m_cnt = 0;
          end
        end
        if (req == 2) begin
          if (m_y + 144 + step <= 766) m_y = m_y + step;
          else begin m_y = 622; m_hb = 1; m_v = 1; m_cnt = 0; end
        end else begin
          if (m_y >= 1 + step) m_y = m_y - step;
          else begin m_y = 1; m_ht = 1; m_v = 1; m_cnt = 0; end
        end
      end
    end
    m_s2u = m_s1u; m_s1u = int'(bus.up_in);
    m_s2d = m_s1d; m_s1d = int'(bus.down_in);
  endtask

  task automatic compare_all();
    chk("y_pad", int'(bus.y_pad), m_y);
    chk("velocity", int'(bus.velocity), m_v);
    chk("moving", int'(bus.moving), (m_dir != 0) ? 1 : 0);
    chk("hit_top", int'(bus.hit_top), m_ht);
    chk("hit_bottom", int'(bus.hit_bottom), m_hb);
  endtask

  task automatic cyc(input bit tk, input bit up, input bit dn, input bit md,
                     input int ball, input int st);
    @(negedge clk);
    bus.timing_tick = tk;
    bus.up_in       = up;
    bus.down_in     = dn;
    bus.mode        = md;
    bus.ball_y      = 10'(ball);
    bus.state       = 2'(st);
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    int acc_exp[5];
    int ycap;
    bit seen;
    bit r_up, r_dn, r_md;
    acc_exp = '{313, 314, 315, 316, 318};

    rst = 1'b0;
    bus.timing_tick = 1'b0; bus.up_in = 1'b0; bus.down_in = 1'b0;
    bus.mode = 1'b0; bus.ball_y = '0; bus.state = 2'b01;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b1;

    // Acceleration with down held
    repeat (2) cyc(0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 1, 0, 0, 1);
      chk("accel_y", int'(bus.y_pad), acc_exp[i]);
      if (i == 3) chk("accel_vel", int'(bus.velocity), 2);
    end

    // Run into the bottom limit
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      cyc(1, 0, 1, 0, 0, 1);
      seen = bus.hit_bottom;
    end
    chk("bot_seen", int'(seen), 1);
    chk("bot_y", int'(bus.y_pad), 622);
    chk("bot_vel", int'(bus.velocity), 1);
    cyc(1, 0, 1, 0, 0, 1);
    chk("bot_again", int'(bus.hit_bottom), 1);
    cyc(0, 0, 1, 0, 0, 1);
    chk("bot_pulse_end", int'(bus.hit_bottom), 0);

    // Both buttons: no move, idle
    repeat (2) cyc(0, 1, 1, 0, 0, 1);
    cyc(1, 1, 1, 0, 0, 1);
    chk("conflict_y", int'(bus.y_pad), 622);
    chk("conflict_idle", int'(bus.moving), 0);

    // Leave play, then reversal from velocity 3
    cyc(0, 0, 0, 0, 0, 2);
    chk("leave_y", int'(bus.y_pad), 312);
    repeat (2) cyc(0, 0, 1, 0, 0, 1);
    repeat (8) cyc(1, 0, 1, 0, 0, 1);
    chk("rev_pre_vel", int'(bus.velocity), 3);
    repeat (2) cyc(0, 1, 0, 0, 0, 1);
    ycap = int'(bus.y_pad);
    cyc(1, 1, 0, 0, 0, 1);
    chk("rev_y", int'(bus.y_pad), ycap - 1);
    chk("rev_vel", int'(bus.velocity), 1);

    // Run into the top limit
    seen = 0;
    for (int i = 0; i < 600 && !seen; i++) begin
      cyc(1, 1, 0, 0, 0, 1);
      seen = bus.hit_top;
    end
    chk("top_seen", int'(seen), 1);
    chk("top_y", int'(bus.y_pad), 1);
    cyc(1, 1, 0, 0, 0, 1);
    chk("top_again", int'(bus.hit_top), 1);

    // Auto tracking
    cyc(0, 0, 0, 1, 386, 2);
    cyc(1, 0, 0, 1, 386, 1);
    chk("auto_none_y", int'(bus.y_pad), 312);
    chk("auto_none_idle", int'(bus.moving), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 1, 100, 1);
      chk("auto_up_y", int'(bus.y_pad), 311 - i);
    end

    // Random traffic
    r_up = 0; r_dn = 0; r_md = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) r_up = 1'($urandom);
      if ($urandom_range(0, 7) == 0) r_dn = 1'($urandom);
      if ($urandom_range(0, 63) == 0) r_md = ~r_md;
      cyc(($urandom_range(0, 3) != 0), r_up, r_dn, r_md,
          int'($urandom_range(0, 1023)),
          ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : 1);
    end

    // Asynchronous reset between edges
    repeat (3) cyc(1, 0, 1, 0, 0, 1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("async_y", int'(bus.y_pad), 312);
    chk("async_vel", int'(bus.velocity), 0);
    chk("async_moving", int'(bus.moving), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pad_motion_ctrl.md
PAD_MOTION_CTRL -- requirements
Module: pad_motion_ctrl

Interface
REQ-001 SHALL have parameters:
- Y_W, 10, width of all vertical coordinates.
- PAD_HEIGHT, 145, pad height in pixels.
- Y_RESET, 312, pad top position when held.
- Y_MIN, 1, smallest allowed pad top.
- Y_MAX, 766, largest allowed pad bottom.
- V_MIN, 1, start velocity in px/tick.
- V_MAX, 4, velocity ceiling.
- ACCEL_TICKS, 4, same-direction moves per velocity step; must be >= 2.
- DEADBAND, 4, auto-mode tolerance in px.
- PLAY_CODE, 2'b01, state value that enables motion.

REQ-002 SHALL have ports:
- clk, in, 1, single system clock.
- rst, in, 1, asynchronous active-low reset.
- timing_tick, in, 1, one-clk motion strobe.
- up_in, in, 1, async up request.
- down_in, in, 1, async down request.
- mode, in, 1, 0=manual, 1=auto track.
- ball_y, in, Y_W, ball vertical position (auto mode).
- state, in, 2, game state.
- y_pad, out, Y_W, registered pad top.
- velocity, out, 3, current px/tick (0 when idle).
- moving, out, 1, FSM not IDLE.
- hit_top, out, 1, one-clk pulse on top clamp.
- hit_bottom, out, 1, one-clk pulse on bottom clamp.

Function
REQ-003 SHALL pass up_in and down_in through a 2-flop synchroniser, giving 2 clk latency to request decode.
REQ-004 In manual mode the request SHALL be: UP if up&!down; DOWN if down&!up; NONE if both or neither.
REQ-005 In auto mode, with center = y_pad + PAD_HEIGHT/2 computed Y_W+1 bits wide, the request SHALL be:
- UP if ball_y < center-DEADBAND.
- DOWN if ball_y > center+DEADBAND.
- NONE otherwise.
Synchronised buttons SHALL be ignored in auto mode.
REQ-006 The FSM SHALL have states IDLE, MOVE_UP and MOVE_DOWN, and SHALL change state only on clock edges where timing_tick=1.
REQ-007 On a tick with NONE, the FSM SHALL go to IDLE, set velocity=0, clear the accel counter, and leave y_pad unchanged.
REQ-008 On a tick with a request different from the current direction (including from IDLE), the FSM SHALL enter that direction, move by V_MIN, and set velocity=V_MIN, accel counter=1.
REQ-009 On a tick with a request equal to the current direction, the block SHALL:
- Move by velocity and increment the counter.
- When the counter reaches ACCEL_TICKS, set velocity=min(velocity+1,V_MAX) and clear the counter.
REQ-010 A down move SHALL work as follows:
- If y_pad+PAD_HEIGHT-1+v <= Y_MAX, y_pad += v.
- Otherwise y_pad = Y_MAX-PAD_HEIGHT+1, hit_bottom=1 for one clk, velocity=V_MIN, counter=0.
REQ-011 An up move SHALL work as follows:
- If y_pad >= Y_MIN+v, y_pad -= v.
- Otherwise y_pad = Y_MIN, hit_top=1 for one clk, velocity=V_MIN, counter=0.
REQ-012 All boundary arithmetic SHALL use Y_W+1 bits so no wrap-around occurs.
REQ-013 y_pad SHALL update on the same clk edge that samples timing_tick=1, with no other latency.
REQ-014 Ticks with the pad already at the limit and a request toward that limit SHALL leave y_pad unchanged and pulse the hit flag again.
REQ-015 While state != PLAY_CODE, on every clk edge the block SHALL set y_pad=Y_RESET, FSM=IDLE, velocity=0, counter=0 and hit flags=0. This overrides timing_tick.
REQ-016 A mode change SHALL take effect at the next tick with no other side effects; velocity continues only if the new request equals the current direction.

Reset
REQ-017 rst=0 SHALL immediately set, regardless of clk:
- y_pad=Y_RESET.
- FSM=IDLE.
- velocity=0, counter=0.
- moving=0, hit_top=0, hit_bottom=0.
- Synchroniser flops=0.
REQ-018 Release of rst SHALL be followed by normal operation from the next clk edge; the first request is visible 2 clk later per REQ-003.

Verification
REQ-019 The bench SHALL cover these directed scenarios (defaults):
- Reset: assert rst=0 mid-clock -> y_pad=312, velocity=0, moving=0 with no clk edge.
- Acceleration: state=01, down held, 5 ticks -> y_pad 313,314,315,316,318; velocity=2 after tick 4.
- Bottom clamp: y_pad=620, MOVE_DOWN, velocity=3, tick -> y_pad=622, hit_bottom high 1 clk, velocity=1.
- Conflict and reversal: up+down held, tick -> y_pad unchanged, IDLE. Moving down at velocity 3, up only, tick -> y_pad-1, velocity=1.
- Auto mode: mode=1, y_pad=312, ball_y=100 -> moves up each tick. ball_y=386 -> NONE, IDLE.
- Leave play: state=10 during MOVE_UP with velocity=4 -> next clk y_pad=312, velocity=0; top clamp at y_pad=2, velocity=2 -> y_pad=1, hit_top pulse.
